// File: rtl/hub75_scan.sv
// ---------------------------------------------------------------------------
// hub75_scan
// Read-side scanner for the double-buffered LED frame memory. Walks the
// display bank row by row (upper and lower half RAMs in parallel) and emits
// HUB75 shift/latch/enable sequences for a 32x32, 1:16-scan panel using
// binary-coded modulation over 8 bit-planes per colour channel.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   display_buffer  bank to display, sampled at reset release / frame wrap
//   rd_addr         {bank, row[3:0], col[4:0]} memory read address (registered)
//   rd_data_hi      upper-half pixel {R,G,B}, one cycle read latency
//   rd_data_lo      lower-half pixel {R,G,B}, one cycle read latency
//   r0,g0,b0        upper-half colour bits to panel
//   r1,g1,b1        lower-half colour bits to panel
//   panel_clk       panel shift clock
//   lat             panel latch strobe
//   oe_n            panel output enable, active-low
//   row_addr        panel row select A-D
//   frame_done      one-cycle pulse in the first cycle of a new frame
// ---------------------------------------------------------------------------
module hub75_scan #(
    parameter int BASE_TIME = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        display_buffer,
    output logic [9:0]  rd_addr,
    input  logic [23:0] rd_data_hi,
    input  logic [23:0] rd_data_lo,
    output logic        r0,
    output logic        g0,
    output logic        b0,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic        panel_clk,
    output logic        lat,
    output logic        oe_n,
    output logic [3:0]  row_addr,
    output logic        frame_done
);

    // Counter must hold both the 65-cycle shift phase and the plane-7 enable.
    localparam int DW = $clog2(BASE_TIME * 128 + 1);
    localparam int CW = (DW > 7) ? DW : 7;

    typedef enum logic [1:0] {
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      plane_q, plane_d;
    logic [3:0]      row_q, row_d;
    logic            bank_q, bank_d;
    logic            start_q;
    logic            wrap;
    logic [CW-1:0]   disp_last;

    logic [9:0]      rd_addr_q, rd_addr_d;
    logic [5:0]      rgb_q, rgb_d;
    logic            pclk_q, pclk_d;
    logic            lat_q, lat_d;
    logic            oen_q, oen_d;
    logic [3:0]      row_addr_q, row_addr_d;
    logic            fd_q, fd_d;

    logic [7:0]      hr, hg, hb, lr, lg, lb;

    assign disp_last = (CW'(BASE_TIME) << plane_q) - CW'(1);

    // ------------------------------------------------------------------
    // State register (all registers, including registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SHIFT;
            cnt_q      <= '0;
            plane_q    <= '0;
            row_q      <= '0;
            bank_q     <= 1'b0;
            start_q    <= 1'b1;
            rd_addr_q  <= '0;
            rgb_q      <= '0;
            pclk_q     <= 1'b0;
            lat_q      <= 1'b0;
            oen_q      <= 1'b1;
            row_addr_q <= '0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            plane_q    <= plane_d;
            row_q      <= row_d;
            bank_q     <= bank_d;
            start_q    <= 1'b0;
            rd_addr_q  <= rd_addr_d;
            rgb_q      <= rgb_d;
            pclk_q     <= pclk_d;
            lat_q      <= lat_d;
            oen_q      <= oen_d;
            row_addr_q <= row_addr_d;
            fd_q       <= fd_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. start_q marks the idle cycle held in reset so the
    // first edge after release begins SHIFT cycle 0 with the bank sampled.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        plane_d = plane_q;
        row_d   = row_q;
        bank_d  = bank_q;
        wrap    = 1'b0;
        if (start_q) begin
            state_d = SHIFT;
            cnt_d   = '0;
            plane_d = '0;
            row_d   = '0;
            bank_d  = display_buffer;
        end else begin
            unique case (state_q)
                SHIFT: begin
                    if (cnt_q == CW'(64)) begin
                        state_d = LATCH;
                        cnt_d   = '0;
                    end
                end
                LATCH: begin
                    state_d = DISPLAY;
                    cnt_d   = '0;
                end
                DISPLAY: begin
                    if (cnt_q == disp_last) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        plane_d = plane_q + 3'd1;
                        if (plane_q == 3'd7) begin
                            row_d = row_q + 4'd1;
                            if (row_q == 4'd15) begin
                                wrap   = 1'b1;
                                bank_d = display_buffer;
                            end
                        end
                    end
                end
                default: begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    assign hr = rd_data_hi[23:16];
    assign hg = rd_data_hi[15:8];
    assign hb = rd_data_hi[7:0];
    assign lr = rd_data_lo[23:16];
    assign lg = rd_data_lo[15:8];
    assign lb = rd_data_lo[7:0];

    always_comb begin
        rd_addr_d = rd_addr_q;
        if (state_d == SHIFT && cnt_d <= CW'(63))
            rd_addr_d = {bank_d, row_d, cnt_d[5:1]};

        // Pixel (k-1)/2 arrives one cycle after its address; capture it at
        // the end of each odd shift cycle.
        rgb_d = rgb_q;
        if (!start_q && state_q == SHIFT && cnt_q[0])
            rgb_d = {hr[plane_q], hg[plane_q], hb[plane_q],
                     lr[plane_q], lg[plane_q], lb[plane_q]};

        pclk_d     = (state_d == SHIFT) && (cnt_d >= CW'(2)) && !cnt_d[0];
        lat_d      = (state_d == LATCH);
        oen_d      = (state_d != DISPLAY);
        row_addr_d = (state_d == LATCH) ? row_d : row_addr_q;
        fd_d       = wrap;
    end

    assign rd_addr    = rd_addr_q;
    assign {r0, g0, b0, r1, g1, b1} = rgb_q;
    assign panel_clk  = pclk_q;
    assign lat        = lat_q;
    assign oe_n       = oen_q;
    assign row_addr   = row_addr_q;
    assign frame_done = fd_q;

endmodule
